count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
Controller that sequences the 4-bit parallel-load up-counter used by the HEX display path. It loads a start value, generates the count-enable ticks at a selectable rate from an internal divider, and supports pause/resume. It stops the counter when its output reaches a programmed stop value. It sits between the board switches/keys and the counter, replacing the free-running rate-driver/mux arrangement.

Parameters:
TICK_DIV, 50000000, clock cycles per base tick (1 Hz at 50 MHz); must be >= 2
DIV_W, 28, divider width; must hold 4*TICK_DIV-1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin sequence (level, sampled each cycle)
pause  in  1  one-cycle pulse; toggles RUN<->PAUSE
clear  in  1  abort to IDLE
start_val  in  4  value loaded into counter
stop_val  in  4  counter value at which sequence ends
freq_sel  in  2  00 every cycle, 01 TICK_DIV, 10 2*TICK_DIV, 11 4*TICK_DIV cycles per tick
cnt_q  in  4  counter output (registered, wraps 15->0)
cnt_load  out  4  parallel-load data to counter
cnt_par_load  out  1  counter parallel-load strobe
cnt_enable  out  1  counter increment enable
busy  out  1  state is LOAD, RUN or PAUSE
done  out  1  state is DONE
state  out  3  IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4

Behaviour:
- Reset (synchronous, takes priority over all inputs): state=IDLE; divider=0; latched freq=00; latched start/stop=0. All outputs 0.
- Input priority within a cycle: reset > clear > stop match > pause > start.
- IDLE: start=1 -> LOAD. Otherwise hold.
- LOAD (exactly 1 cycle): cnt_par_load=1, cnt_load=latched start_val. Latches start_val, stop_val and freq_sel on entry; later changes are ignored until the next LOAD. Divider loads reload value R: 0 for sel 00, TICK_DIV-1 for 01, 2*TICK_DIV-1 for 10, 4*TICK_DIV-1 for 11. Next state is RUN.
- RUN:
  - match = (cnt_q == latched stop_val). If match, go to DONE; cnt_enable=0 that cycle.
  - Divider decrements each cycle. tick = (divider==0); on tick the divider reloads R.
  - cnt_enable = tick & ~match.
  - First tick occurs on the (R+1)th RUN cycle. With sel 00, tick is every cycle.
  - pause=1 and no match -> PAUSE.
  - start is ignored.
- PAUSE: divider frozen; cnt_enable=0. pause=1 -> RUN, with the divider resuming from its frozen value. start is ignored.
- DONE: done=1, cnt_enable=0. Holds until start=1 (-> LOAD) or clear (-> IDLE).
- clear in any state -> IDLE next cycle; divider cleared to 0.
- Wrap-around: stop_val < start_val is legal; the counter counts through 15->0.
  - start_val == stop_val: LOAD, then one RUN cycle with match, then DONE. Zero increments.
- Outputs are combinational decodes of the registered state/divider. There is no extra latency.
- Counter value observed by the controller lags cnt_enable by one cycle. This guarantees the counter holds exactly stop_val in DONE.

Optional Feature:
AUTO_RELOAD_EN
- Defined: DONE lasts exactly one cycle (done pulses), then the block goes to LOAD automatically with the same latched values. This loops until clear or reset. A new start_val/stop_val/freq_sel is taken only after clear->IDLE->start.
- Undefined: DONE holds as described above.

Test Plan:
All cases use TICK_DIV=4.
1. Reset asserted mid-RUN -> next cycle state=0; cnt_par_load, cnt_enable, busy and done all 0.
2. start_val=3, stop_val=6, freq_sel=01, start pulse -> LOAD one cycle with cnt_load=3. cnt_enable pulses on RUN cycles 4, 8 and 12. cnt_q reaches 6, then state=4, done=1 and cnt_q stays 6.
3. start_val=14, stop_val=1, freq_sel=00 -> cnt_enable high 3 consecutive cycles (14->15->0->1), then DONE.
4. start_val=stop_val=9 -> LOAD, one RUN cycle, DONE with zero cnt_enable pulses.
5. freq_sel=10, pause pulse at RUN cycle 3 -> no cnt_enable while in PAUSE. After a second pause pulse, the first tick comes 5 cycles after resume (divider resumes from 4). pause in the same cycle as match -> DONE.
6. clear during PAUSE -> IDLE next cycle. With AUTO_RELOAD_EN, test 2 repeats: done is a 1-cycle pulse, then cnt_par_load=1 loads 3 again.

Source files
------------

// File: rtl/count_sequencer.sv
// Sequencer for the 4-bit parallel-load up-counter: load, rate-divided count ticks, pause/resume, stop on match.
// Optional macro AUTO_RELOAD_EN: DONE pulses for one cycle and the sequence reloads with the same latched values.
module count_sequencer #(
   parameter int TICK_DIV = 50000000,
   parameter int DIV_W    = 28
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic [3:0] start_val,
   input  logic [3:0] stop_val,
   input  logic [1:0] freq_sel,
   input  logic [3:0] cnt_q,
   output logic [3:0] cnt_load,
   output logic       cnt_par_load,
   output logic       cnt_enable,
   output logic       busy,
   output logic       done,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [DIV_W-1:0] LP_R1 = DIV_W'(TICK_DIV - 1);
   localparam logic [DIV_W-1:0] LP_R2 = DIV_W'(2 * TICK_DIV - 1);
   localparam logic [DIV_W-1:0] LP_R4 = DIV_W'(4 * TICK_DIV - 1);

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_freq;
   logic [3:0]       r_start;
   logic [3:0]       r_stop;

   logic [DIV_W-1:0] w_reload;
   logic             w_tick;
   logic             w_match;

   always_comb begin
      w_reload = '0;
      case (r_freq)
         2'b01:   w_reload = LP_R1;
         2'b10:   w_reload = LP_R2;
         2'b11:   w_reload = LP_R4;
         default: w_reload = '0;
      endcase
   end

   assign w_tick  = (r_div == '0);
   assign w_match = (cnt_q == r_stop);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_freq  <= '0;
         r_start <= '0;
         r_stop  <= '0;
      end else if (clear) begin
         r_state <= S_IDLE;
         r_div   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LOAD;
                  r_start <= start_val;
                  r_stop  <= stop_val;
                  r_freq  <= freq_sel;
               end
            end
            S_LOAD: begin
               r_state <= S_RUN;
               r_div   <= w_reload;
            end
            S_RUN: begin
               // A match ends the run before pause is considered.
               if (w_match) begin
                  r_state <= S_DONE;
               end else begin
                  r_div <= w_tick ? w_reload : r_div - DIV_W'(1);
                  if (pause) r_state <= S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (pause) r_state <= S_RUN;
            end
            S_DONE: begin
`ifdef AUTO_RELOAD_EN
               r_state <= S_LOAD;
`else
               if (start) begin
                  r_state <= S_LOAD;
                  r_start <= start_val;
                  r_stop  <= stop_val;
                  r_freq  <= freq_sel;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign state        = r_state;
   assign cnt_load     = r_start;
   assign cnt_par_load = (r_state == S_LOAD);
   assign cnt_enable   = (r_state == S_RUN) && w_tick && !w_match;
   assign busy         = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSE);
   assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with TICK_DIV=4 and a behavioural model of the 4-bit counter it drives.
module tb_count_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] start_val = '0;
   logic [3:0] stop_val  = '0;
   logic [1:0] freq_sel  = '0;
   logic [3:0] cnt_q;
   logic [3:0] cnt_load;
   logic       cnt_par_load;
   logic       cnt_enable;
   logic       busy;
   logic       done;
   logic [2:0] state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   count_sequencer #(.TICK_DIV(4), .DIV_W(28)) dut (
      .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear),
      .start_val(start_val), .stop_val(stop_val), .freq_sel(freq_sel), .cnt_q(cnt_q),
      .cnt_load(cnt_load), .cnt_par_load(cnt_par_load), .cnt_enable(cnt_enable),
      .busy(busy), .done(done), .state(state)
   );

   // External counter: parallel load wins over increment, wraps 15->0.
   always @(posedge clock) begin
      if (reset)             cnt_q <= 4'd0;
      else if (cnt_par_load) cnt_q <= cnt_load;
      else if (cnt_enable)   cnt_q <= cnt_q + 4'd1;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic begin_seq(input logic [3:0] sv, input logic [3:0] ev, input logic [1:0] fs);
      clear = 1'b1;
      step();
      clear = 1'b0;
      start_val = sv; stop_val = ev; freq_sel = fs; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      logic exp_en;
      logic [3:0] exp_q;

      // Reset state
      step(); step();
      chk("rst_state", state, 3'd0);
      chk("rst_outs", {cnt_load, cnt_par_load, cnt_enable, busy, done}, 8'h00);
      reset = 1'b0;
      step();
      chk("idle_hold", state, 3'd0);

      // Test 1: reset mid-RUN
      begin_seq(4'd2, 4'd9, 2'b00);
      step(); step();
      chk("t1_run", state, 3'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t1_state", state, 3'd0);
      chk("t1_outs", {cnt_par_load, cnt_enable, busy, done}, 4'b0000);

      // Test 2: 3 -> 6 at TICK_DIV rate, ticks on RUN cycles 4, 8, 12
      begin_seq(4'd3, 4'd6, 2'b01);
      chk("t2_load_state", state, 3'd1);
      chk("t2_load", {cnt_par_load, cnt_load}, 5'h13);
      chk("t2_load_busy", busy, 1'b1);
      start_val = 4'd11;  // must be ignored once latched
      step();
      exp_q = 4'd3;
      for (int k = 1; k <= 13; k++) begin
         exp_en = (k == 4 || k == 8 || k == 12);
         chk($sformatf("t2_state_c%0d", k), state, 3'd2);
         chk($sformatf("t2_en_c%0d", k), cnt_enable, exp_en);
         chk($sformatf("t2_q_c%0d", k), cnt_q, exp_q);
         if (exp_en) exp_q = exp_q + 4'd1;
         step();
      end
      chk("t2_done_state", state, 3'd4);
      chk("t2_done_flag", {done, busy, cnt_enable}, 3'b100);
      chk("t2_done_q", cnt_q, 4'd6);
      step();
`ifdef AUTO_RELOAD_EN
      chk("t6_auto_reload", {state, cnt_par_load, cnt_load}, {3'd1, 1'b1, 4'd3});
      chk("t6_done_pulse", done, 1'b0);
`else
      chk("t2_done_hold", {state, done}, {3'd4, 1'b1});
      chk("t2_hold_q", cnt_q, 4'd6);
`endif

      // Test 3: wrap 14 -> 15 -> 0 -> 1 at full rate
      begin_seq(4'd14, 4'd1, 2'b00);
      chk("t3_load", cnt_load, 4'd14);
      step();
      exp_q = 4'd14;
      for (int k = 1; k <= 4; k++) begin
         exp_en = (k <= 3);
         chk($sformatf("t3_en_c%0d", k), cnt_enable, exp_en);
         chk($sformatf("t3_q_c%0d", k), cnt_q, exp_q);
         exp_q = exp_q + 4'd1;
         step();
      end
      chk("t3_done", {state, cnt_q}, {3'd4, 4'd1});

      // Test 4: start == stop, zero increments
      begin_seq(4'd9, 4'd9, 2'b01);
      chk("t4_load", state, 3'd1);
      step();
      chk("t4_run", {state, cnt_enable, cnt_q}, {3'd2, 1'b0, 4'd9});
      step();
      chk("t4_done", {state, done, cnt_q}, {3'd4, 1'b1, 4'd9});

      // Test 5: 2*TICK_DIV rate, pause at RUN cycle 3, resume, pause coincident with match
      begin_seq(4'd0, 4'd2, 2'b10);
      step();
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("t5_pre_en_c%0d", k), cnt_enable, 1'b0);
         if (k == 3) pause = 1'b1;
         step();
      end
      pause = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("t5_paused_c%0d", k), {state, cnt_enable, busy}, {3'd3, 1'b0, 1'b1});
         if (k == 3) pause = 1'b1;
         step();
      end
      pause = 1'b0;
      for (int r = 1; r <= 14; r++) begin
         exp_en = (r == 5 || r == 13);
         exp_q  = (r <= 5) ? 4'd0 : (r <= 13) ? 4'd1 : 4'd2;
         chk($sformatf("t5_en_r%0d", r), {state, cnt_enable}, {3'd2, exp_en});
         chk($sformatf("t5_q_r%0d", r), cnt_q, exp_q);
         if (r == 14) pause = 1'b1;
         step();
      end
      pause = 1'b0;
      chk("t5_pause_vs_match", state, 3'd4);

      // Test 6: clear during PAUSE
      begin_seq(4'd5, 4'd7, 2'b01);
      step();
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("t6_paused", state, 3'd3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t6_cleared", {state, busy, done, cnt_enable, cnt_par_load}, {3'd0, 4'b0000});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
